prism_sp_puzzle_fifo: RTL and testbench

Buffered first-word-fall-through FIFO sitting directly downstream of the puzzle FIFO mixer. Each mixer master port pair (`puzzle_fifo_w_N`, `puzzle_fifo_r_N`) terminates in one instance of this block. A hardware or software producer writes into the buffer, and a hardware or software consumer drains it. The block provides level reporting, an almost-full threshold, and sticky error flags for software diagnostics.

---
 rtl/prism_sp_puzzle_fifo.sv | 118 +++++++++++
 tb/tb_prism_sp_puzzle_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/prism_sp_puzzle_fifo.sv
// First-word-fall-through FIFO with level, almost-full and sticky error flags.
// Optional statistics counters are compiled in with PRISM_SP_PUZZLE_FIFO_STATS_EN.
module prism_sp_puzzle_fifo #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clear_err
`ifdef PRISM_SP_PUZZLE_FIFO_STATS_EN
    ,
    output logic [31:0]              stat_words,
    output logic [15:0]              stat_drops,
    output logic [$clog2(DEPTH):0]   stat_hiwater
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc, wr_rej, rd_rej;

    always_comb begin
        empty       = (wr_ptr_q == rd_ptr_q);
        full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        level       = wr_ptr_q - rd_ptr_q;
        almost_full = (level >= PW'(AFULL_LEVEL));
        rd_data     = mem_q[rd_ptr_q[AW-1:0]];

        wr_acc = wr_en & ~full;
        wr_rej = wr_en & full;
        rd_acc = rd_en & ~empty;
        rd_rej = rd_en & empty;

        wr_ptr_d = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d = rd_ptr_q + PW'(rd_acc);

        // A fresh error in the clearing cycle must survive the clear.
        overflow_d  = (overflow_q & ~clear_err) | wr_rej;
        underflow_d = (underflow_q & ~clear_err) | rd_rej;

        overflow  = overflow_q;
        underflow = underflow_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; the pointers define validity.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

`ifdef PRISM_SP_PUZZLE_FIFO_STATS_EN
    logic [31:0]   stat_words_q, stat_words_d, words_base;
    logic [15:0]   stat_drops_q, stat_drops_d, drops_base;
    logic [PW-1:0] stat_hiwater_q, stat_hiwater_d;

    always_comb begin
        words_base   = clear_err ? '0 : stat_words_q;
        drops_base   = clear_err ? '0 : stat_drops_q;
        stat_words_d = words_base + 32'(wr_acc);
        stat_drops_d = (wr_rej && (drops_base != 16'hFFFF)) ? drops_base + 16'd1 : drops_base;
        if (clear_err) begin
            stat_hiwater_d = '0;
        end else if (level > stat_hiwater_q) begin
            stat_hiwater_d = level;
        end else begin
            stat_hiwater_d = stat_hiwater_q;
        end
        stat_words   = stat_words_q;
        stat_drops   = stat_drops_q;
        stat_hiwater = stat_hiwater_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stat_words_q   <= '0;
            stat_drops_q   <= '0;
            stat_hiwater_q <= '0;
        end else begin
            stat_words_q   <= stat_words_d;
            stat_drops_q   <= stat_drops_d;
            stat_hiwater_q <= stat_hiwater_d;
        end
    end
`endif

endmodule

// File: tb/tb_prism_sp_puzzle_fifo.sv
// Bench for prism_sp_puzzle_fifo: directed scenarios plus random traffic against a queue model.
module tb_prism_sp_puzzle_fifo;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int AF = 6;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_en = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          full, almost_full, empty, overflow, underflow;
    logic          rd_en = 1'b0;
    logic [W-1:0]  rd_data;
    logic [3:0]    level;
    logic          clear_err = 1'b0;
`ifdef PRISM_SP_PUZZLE_FIFO_STATS_EN
    logic [31:0]   stat_words;
    logic [15:0]   stat_drops;
    logic [3:0]    stat_hiwater;
`endif

    always #5 clock = ~clock;

    prism_sp_puzzle_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow),
        .clear_err   (clear_err)
`ifdef PRISM_SP_PUZZLE_FIFO_STATS_EN
        ,
        .stat_words  (stat_words),
        .stat_drops  (stat_drops),
        .stat_hiwater(stat_hiwater)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    bit           ovf_m, unf_m;
    int unsigned  words_m, drops_m, hi_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == D));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= AF));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
        chk({tag, ".underflow"}, 32'(underflow), 32'(unf_m));
        if (q.size() != 0) chk({tag, ".rd_data"}, rd_data, q[0]);
`ifdef PRISM_SP_PUZZLE_FIFO_STATS_EN
        chk({tag, ".stat_words"}, stat_words, words_m);
        chk({tag, ".stat_drops"}, 32'(stat_drops), drops_m);
        chk({tag, ".stat_hiwater"}, 32'(stat_hiwater), hi_m);
`endif
    endtask

    task automatic model_clear();
        q.delete();
        ovf_m = 0; unf_m = 0;
        words_m = 0; drops_m = 0; hi_m = 0;
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic cycle(input string tag, input bit we, input logic [W-1:0] wd, input bit re, input bit ce);
        bit was_full, was_empty, wacc, racc;
        int pre;
        wr_en = we; wr_data = wd; rd_en = re; clear_err = ce;
        @(posedge clock);
        pre       = q.size();
        was_full  = (pre == D);
        was_empty = (pre == 0);
        wacc = we && !was_full;
        racc = re && !was_empty;
        if (racc) void'(q.pop_front());
        if (wacc) q.push_back(wd);
        if (ce) begin ovf_m = 0; unf_m = 0; end
        if (we && was_full) ovf_m = 1;
        if (re && was_empty) unf_m = 1;
        if (ce) begin words_m = 0; drops_m = 0; end
        words_m += wacc ? 1 : 0;
        if (we && was_full && drops_m != 16'hFFFF) drops_m++;
        hi_m = ce ? 0 : ((pre > int'(hi_m)) ? pre : hi_m);
        #1;
        wr_en = 0; rd_en = 0; clear_err = 0;
        check_all(tag);
    endtask

    task automatic reset_mid_cycle(input string tag);
        #2;
        resetn = 1'b0;
        #1;
        model_clear();
        check_all(tag);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        model_clear();
        #1;
        check_all("reset");
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;

        // Fill with 0xA0..0xA7.
        for (int i = 0; i < D; i++) cycle("fill", 1, 32'hA0 + 32'(i), 0, 0);
        // Full: write 0xFF with a read; write dropped, overflow set.
        cycle("full_wr_rd", 1, 32'hFF, 1, 0);
        cycle("clear_ovf", 0, '0, 0, 1);
        // Drain, then underflow and clear.
        while (q.size() != 0) cycle("drain", 0, '0, 1, 0);
        cycle("underflow", 0, '0, 1, 0);
        cycle("clear_unf", 0, '0, 0, 1);
        // Clear coinciding with a new error: set wins.
        cycle("clr_vs_set", 0, '0, 1, 1);
        cycle("clear_again", 0, '0, 0, 1);

        // Streaming 20 words, reads lagging one cycle.
        cycle("stream", 1, 32'h100, 0, 0);
        for (int i = 1; i < 20; i++) cycle("stream", 1, 32'h100 + 32'(i), 1, 0);
        cycle("stream_tail", 0, '0, 1, 0);

        // Mid-operation async reset after 5 entries.
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1, 32'h200 + 32'(i), 0, 0);
        reset_mid_cycle("async_rst");
        cycle("post_rst_wr", 1, 32'h55, 0, 0);
        cycle("post_rst_rd", 0, '0, 1, 0);

        // Random traffic, alternating fill-biased and drain-biased phases.
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 50; i++) begin
                int wp = (ph % 2 == 0) ? 75 : 30;
                int rp = (ph % 2 == 0) ? 30 : 75;
                cycle("random", $urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp,
                      $urandom_range(0, 99) < 3);
            end
        end

`ifdef PRISM_SP_PUZZLE_FIFO_STATS_EN
        reset_mid_cycle("stats_rst");
        for (int i = 0; i < 10; i++) cycle("stats_fill", 1, 32'h300 + 32'(i), 0, 0);
        chk("stats.words8", stat_words, 32'd8);
        chk("stats.drops2", 32'(stat_drops), 32'd2);
        chk("stats.hiwater8", 32'(stat_hiwater), 32'd8);
        cycle("stats_clear", 0, '0, 0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
